// File: rtl/led_flow_monitor_if.sv
// Bundle of the LED bus, the clear pulse and every observation output of
// led_flow_monitor. The lights side (or a bench) uses the master view; the
// monitor itself uses the slave view.
interface led_flow_monitor_if;
  logic [7:0]  led;
  logic        clr;
  logic [2:0]  pos;
  logic        dir;
  logic        running;
  logic [23:0] period;
  logic [15:0] step_cnt;
  logic        locked;
  logic        err;
  logic        fsm_state;

  modport master (
    output led, clr,
    input  pos, dir, running, period, step_cnt, locked, err, fsm_state
  );

  modport slave (
    input  led, clr,
    output pos, dir, running, period, step_cnt, locked, err, fsm_state
  );
endinterface

// File: rtl/led_flow_monitor.sv
// Observer for the 8-bit flowing-water LED bus. Registers the bus once, then
// tracks the lit position against the last accepted pattern, recovering shift
// direction, step period, step count and a running flag, and flagging any
// illegal or non-adjacent pattern in a sticky error bit.
//
// Handshake: there is no valid/ready pair here. led is sampled on every rising
// edge; clr is a single-cycle synchronous pulse honoured on the edge where it
// is high. All outputs are registered (locked/fsm_state decode the state
// register only).
module led_flow_monitor #(
  parameter logic [23:0] STALL_LIMIT = 24'd10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  led_flow_monitor_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [0:0]  state;
  logic [7:0]  led_q;
  logic [7:0]  ref_pat;
  logic [23:0] cnt;
  logic [2:0]  pos_q;
  logic        dir_q;
  logic        running_q;
  logic [23:0] period_q;
  logic [15:0] step_cnt_q;
  logic        err_q;

  logic        led_onehot;
  logic        step_left;
  logic        step_right;
  logic [2:0]  led_idx;
  logic [23:0] cnt_inc;

  // Pattern classification of the registered bus against the reference.
  always_comb begin
    led_onehot = (led_q != 8'd0) && ((led_q & (led_q - 8'd1)) == 8'd0);
    step_left  = ({ref_pat[6:0], ref_pat[7]} == led_q);
    step_right = ({ref_pat[0], ref_pat[7:1]} == led_q);
    led_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (led_q[i]) led_idx = 3'(i);
    end
    // Saturating increment; also serves as the period of an accepted step.
    cnt_inc = (cnt == 24'hFF_FFFF) ? cnt : cnt + 24'd1;
  end

  // Input register, tracking FSM and all observation state. The clr clause
  // sits last so it overrides any error set or step count in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q      <= 8'd0;
      state      <= IDLE;
      ref_pat    <= 8'd0;
      cnt        <= 24'd0;
      pos_q      <= 3'd0;
      dir_q      <= 1'b0;
      running_q  <= 1'b0;
      period_q   <= 24'd0;
      step_cnt_q <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      led_q <= bus.led;
      case (state)
        IDLE: begin
          cnt <= 24'd0;
          if (led_onehot) begin
            ref_pat <= led_q;
            pos_q   <= led_idx;
            state   <= TRACK;
          end
        end
        TRACK: begin
          if (led_q == ref_pat) begin
            cnt <= cnt_inc;
            if (cnt_inc >= STALL_LIMIT) running_q <= 1'b0;
          end else if (step_left || step_right) begin
            ref_pat    <= led_q;
            pos_q      <= led_idx;
            dir_q      <= step_left;
            period_q   <= cnt_inc;
            step_cnt_q <= step_cnt_q + 16'd1;
            running_q  <= 1'b1;
            cnt        <= 24'd0;
          end else if (led_onehot) begin
            // Jump to a non-neighbour: resync without counting a step.
            err_q     <= 1'b1;
            running_q <= 1'b0;
            ref_pat   <= led_q;
            pos_q     <= led_idx;
            cnt       <= 24'd0;
          end else begin
            err_q     <= 1'b1;
            running_q <= 1'b0;
            cnt       <= 24'd0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (bus.clr) begin
        err_q      <= 1'b0;
        step_cnt_q <= 16'd0;
      end
    end
  end

  assign bus.pos       = pos_q;
  assign bus.dir       = dir_q;
  assign bus.running   = running_q;
  assign bus.period    = period_q;
  assign bus.step_cnt  = step_cnt_q;
  assign bus.locked    = (state == TRACK);
  assign bus.err       = err_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_led_flow_monitor.sv
// Directed bench for led_flow_monitor with a short stall limit.
module tb_led_flow_monitor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [7:0] lp;
  logic [7:0] rpat [4];
  logic [31:0] exp_q [$];

  led_flow_monitor_if bus ();

  led_flow_monitor #(.STALL_LIMIT(24'd100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pos"},      32'(bus.pos),      32'd0);
    chk({tag, "_dir"},      32'(bus.dir),      32'd0);
    chk({tag, "_running"},  32'(bus.running),  32'd0);
    chk({tag, "_period"},   32'(bus.period),   32'd0);
    chk({tag, "_step_cnt"}, 32'(bus.step_cnt), 32'd0);
    chk({tag, "_locked"},   32'(bus.locked),   32'd0);
    chk({tag, "_err"},      32'(bus.err),      32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    bus.led  = 8'h01;
    bus.clr  = 1'b0;
    tick(3);
    chk_reset_values("reset");

    // Lock after reset release with 8'h01 held: two edges.
    rst = 1'b1;
    tick(1);
    chk("lock_latency", 32'(bus.locked), 32'd0);
    tick(1);
    chk("lock_locked",   32'(bus.locked),   32'd1);
    chk("lock_pos",      32'(bus.pos),      32'd0);
    chk("lock_running",  32'(bus.running),  32'd0);
    chk("lock_step_cnt", 32'(bus.step_cnt), 32'd0);
    chk("lock_err",      32'(bus.err),      32'd0);

    // Left rotation every 50 cycles, 10 steps through the 80->01 wrap.
    lp = 8'h01;
    for (int i = 0; i < 10; i++) begin
      lp = {lp[6:0], lp[7]};
      bus.led = lp;
      tick(50);
    end
    chk("left_dir",      32'(bus.dir),      32'd1);
    chk("left_period",   32'(bus.period),   32'd50);
    chk("left_step_cnt", 32'(bus.step_cnt), 32'd10);
    chk("left_pos",      32'(bus.pos),      32'd2);
    chk("left_running",  32'(bus.running),  32'd1);

    // Right rotation every 20 cycles from 8'h04 through the 01->80 wrap.
    rpat[0] = 8'h02; rpat[1] = 8'h01; rpat[2] = 8'h80; rpat[3] = 8'h40;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd7); exp_q.push_back(32'd6);
    for (int i = 0; i < 4; i++) begin
      bus.led = rpat[i];
      tick(1);
      if (i == 0) chk("right_latency_pos", 32'(bus.pos), 32'd2);
      tick(1);
      chk("right_pos", 32'(bus.pos), exp_q.pop_front());
      if (i < 3) tick(18);
    end
    chk("right_dir",      32'(bus.dir),      32'd0);
    chk("right_period",   32'(bus.period),   32'd20);
    chk("right_step_cnt", 32'(bus.step_cnt), 32'd14);

    // Stall: running drops on the 102nd edge after the last change.
    tick(99);
    chk("stall_101_running", 32'(bus.running), 32'd1);
    tick(1);
    chk("stall_102_running", 32'(bus.running), 32'd0);
    chk("stall_pos",    32'(bus.pos),    32'd6);
    chk("stall_dir",    32'(bus.dir),    32'd0);
    chk("stall_period", 32'(bus.period), 32'd20);

    // Illegal multi-bit pattern drops lock and sets err.
    bus.led = 8'h03;
    tick(2);
    chk("illegal_err",    32'(bus.err),    32'd1);
    chk("illegal_locked", 32'(bus.locked), 32'd0);
    bus.led = 8'h10;
    tick(2);
    chk("relock_locked", 32'(bus.locked), 32'd1);
    chk("relock_pos",    32'(bus.pos),    32'd4);
    chk("relock_err",    32'(bus.err),    32'd1);

    // Non-adjacent jump: resync, err stays, no step counted.
    bus.led = 8'h40;
    tick(2);
    chk("jump_err",      32'(bus.err),      32'd1);
    chk("jump_pos",      32'(bus.pos),      32'd6);
    chk("jump_step_cnt", 32'(bus.step_cnt), 32'd14);
    chk("jump_period",   32'(bus.period),   32'd20);
    chk("jump_locked",   32'(bus.locked),   32'd1);

    // clr on the same edge as an accepted left step 40->80.
    bus.led = 8'h80;
    tick(1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    chk("clr_err",      32'(bus.err),      32'd0);
    chk("clr_step_cnt", 32'(bus.step_cnt), 32'd0);
    chk("clr_pos",      32'(bus.pos),      32'd7);
    chk("clr_dir",      32'(bus.dir),      32'd1);
    chk("clr_running",  32'(bus.running),  32'd1);
    chk("clr_period",   32'(bus.period),   32'd2);

    // Back-to-back steps 80->01->02: period of 1.
    bus.led = 8'h01;
    tick(1);
    bus.led = 8'h02;
    tick(2);
    chk("k1_period",   32'(bus.period),   32'd1);
    chk("k1_pos",      32'(bus.pos),      32'd1);
    chk("k1_step_cnt", 32'(bus.step_cnt), 32'd2);

    // Asynchronous reset mid-run, checked before any further clock edge.
    #1;
    rst = 1'b0;
    #1;
    chk_reset_values("async_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_flow_monitor.md
# led_flow_monitor

Observer for the 8-bit flowing-water-lights LED bus. It samples the one-hot `led` pattern produced by the lights block and recovers the lit position, shift direction, step period in clock cycles, step count and running status. It flags illegal patterns. It sits beside the lights block at top level, sharing its 100 MHz clock, and feeds on-board self-check logic and the bench scoreboard.

## Interface
- `STALL_LIMIT`, default 24'd10_000_000: cycles without an accepted shift before `running` drops (0.1 s at 100 MHz; benches override it to a small value).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. The port name follows the codebase; the polarity and asynchronous behaviour are fixed.
- `led`  in  8  LED bus from the lights block, synchronous to `clk`.
- `clr`  in  1  synchronous pulse; clears `err` and `step_cnt`.
- `pos`  out  3  index of the lit LED in the last accepted pattern.
- `dir`  out  1  direction of the last accepted shift: 1 = left (toward MSB), 0 = right (toward LSB).
- `running`  out  1  high while accepted shifts keep arriving within `STALL_LIMIT`.
- `period`  out  24  cycles between the last two accepted shifts; saturates at 24'hFF_FFFF.
- `step_cnt`  out  16  number of accepted shifts since reset or `clr`; wraps from 16'hFFFF to 0.
- `locked`  out  1  a valid one-hot pattern is currently being tracked.
- `err`  out  1  sticky illegal-pattern flag.

## Operation
- Input stage:
  - `led` is registered once into `led_q`.
  - `led_q` is compared with the previous accepted pattern `ref`.
- One-hot test: exactly one bit set. 8'h00 and multi-bit values are illegal.
- Adjacency test:
  - Left step: `ref` rotated left by 1 equals `led_q` (wrap 8'h80→8'h01).
  - Right step: `ref` rotated right by 1 equals `led_q` (wrap 8'h01→8'h80).
- FSM with two states, IDLE and TRACK:
  - IDLE: `locked`=0 and the cycle counter is held at 0. When `led_q` is one-hot: `ref`←`led_q`, `pos`←index, `cnt`←0, go to TRACK. When `led_q` is illegal: stay in IDLE; `err` is not set.
  - TRACK, `led_q` == `ref`: `cnt` increments, saturating. When `cnt` reaches `STALL_LIMIT`, `running`←0; the FSM stays in TRACK.
  - TRACK, `led_q` is an adjacent one-hot step (accepted shift): `ref`/`pos` update, `dir` is set from the step direction, `period`←`cnt`+1 (saturating), `step_cnt`+1, `running`←1, `cnt`←0.
  - TRACK, `led_q` is one-hot but not adjacent: `err`←1, `running`←0, `ref`/`pos` resync to the new pattern, `cnt`←0. `dir`, `period` and `step_cnt` are unchanged.
  - TRACK, `led_q` is illegal: `err`←1, `running`←0, `locked`←0, go to IDLE.
- The first accepted shift after entering TRACK sets `running` and `period`. `period` is then measured from lock or resync, not from a previous step.
- `clr` in the same cycle as a step: `err`←0 and `step_cnt`←0 take priority. The step still updates `pos`, `dir`, `period` and `running`.
- Reset mid-operation returns immediately to IDLE with all outputs at their reset values.

## Timing
- Reset values: `pos`=0, `dir`=0, `running`=0, `period`=0, `step_cnt`=0, `locked`=0, `err`=0. The FSM resets to IDLE and `ref` resets to 8'h00.
- Latency: a `led` change sampled at edge N is in `led_q` after N. Outputs reflect it after edge N+1, i.e. 2 cycles.
- `period` accuracy: if `led` shifts every K cycles, `period`=K exactly for K ≥ 1. Back-to-back changes (K=1) give `period`=1.
- `running` falls on the edge where `cnt` reaches `STALL_LIMIT`, i.e. `STALL_LIMIT`+2 cycles after the last `led` change.
- `err` stays at 1 until `clr` or reset.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset release with `led`=8'h01 held: after 2 cycles `locked`=1, `pos`=0, `running`=0, `step_cnt`=0, `err`=0.
- Left rotation every 50 cycles from 8'h01 through the 8'h80→8'h01 wrap, 10 steps: `dir`=1, `period`=50, `step_cnt`=10, `pos`=2, `running`=1.
- Right rotation every 20 cycles from 8'h04 through the 8'h01→8'h80 wrap: `dir`=0, `period`=20, `pos` sequence 1,0,7,6.
- Hold `led` after shifting with `STALL_LIMIT`=100: `running` falls exactly 102 cycles after the last change. `pos`, `dir` and `period` are unchanged.
- Inject 8'h03, then 8'h10: `err`=1 and `locked`=0 after 8'h03, then relock with `pos`=4. Then jump 8'h10→8'h40: `err` stays 1, `pos`=6, `step_cnt` is unchanged.
- `clr` coincident with an accepted step: `err`=0 and `step_cnt`=0, while `pos`/`dir` update. Assert `rst` low mid-run: all outputs take their reset values asynchronously.
